// File: rtl/serial_adder_pkg.sv
// Shared types and helpers for the bit-serial adder: FSM state encoding and
// counter-width sizing.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Bits needed to count W serial steps (0 .. W-1).
  function automatic int cnt_width(input int w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/full_adder_bit.sv
// One-bit full-adder cell; the single arithmetic element shared by every
// serial step.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);

  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: {c_out,sum} = a + b + c_in, one bit per clock,
// LSB first, through one full-adder cell and a carry flip-flop.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         c_in,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] sum,
  output logic         c_out
);

  localparam int                CNT_W    = cnt_width(W);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(W - 1);

  state_t           r_state;
  state_t           w_next_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_acc;
  logic [W-1:0]     r_sum;
  logic             r_carry;
  logic             r_c_out;
  logic [CNT_W-1:0] r_cnt;
  logic             w_s;
  logic             w_co;
  logic             w_last;
  logic [W-1:0]     w_acc_next;

  full_adder_bit u_fa (
    .a  (r_a[0]),
    .b  (r_b[0]),
    .ci (r_carry),
    .s  (w_s),
    .co (w_co)
  );

  assign w_last     = (r_cnt == LAST_CNT);
  assign w_acc_next = {w_s, {(W-1){1'b0}}} | (r_acc >> 1);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: the default assignment first keeps this block purely combinational;
  // a path that left w_next_state unassigned would infer a latch.
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      IDLE:    if (start)  w_next_state = RUN;
      RUN:     if (w_last) w_next_state = DONE;
      DONE:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, so an aborted operation leaves
  // no stale partial result behind.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_acc   <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_c_out <= 1'b0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= c_in;
            r_cnt   <= '0;
            r_acc   <= '0;
          end
        end
        RUN: begin
          r_acc   <= w_acc_next;
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_carry <= w_co;
          r_cnt   <= r_cnt + 1'b1;
          // The last step publishes the freshly completed accumulator.
          if (w_last) begin
            r_sum   <= w_acc_next;
            r_c_out <= w_co;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = (r_state != IDLE);
  assign done  = (r_state == DONE);
  assign sum   = r_sum;
  assign c_out = r_c_out;

endmodule

// File: tb/tb_serial_adder.sv
// Self-checking bench for serial_adder: directed scenarios plus random and
// exhaustive operands against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         c_in;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         c_out;

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  always #5 clk = ~clk;

  serial_adder #(.W(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .c_in  (c_in),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .c_out (c_out)
  );

  always @(negedge clk) if (done === 1'b1) n_done++;

  function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci);
    logic [W:0] r;
    r = {1'b0, x};
    r = r + {1'b0, y} + {{W{1'b0}}, ci};
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request, scrambles operands after acceptance, waits (bounded)
  // for done and reports what was seen.
  task automatic do_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                       output logic [W-1:0] s, output logic co, output int lat,
                       output logic acc_busy, output logic stable);
    logic [W-1:0] held_s;
    logic         held_c;
    held_s = sum;
    held_c = c_out;
    a = x; b = y; c_in = ci; start = 1'b1;
    step();
    start    = 1'b0;
    acc_busy = busy;
    a = W'($urandom); b = W'($urandom); c_in = 1'($urandom);
    lat    = -1;
    stable = 1'b1;
    for (int k = 1; k <= W + 4; k++) begin
      step();
      if (done === 1'b1) begin lat = k; break; end
      if (sum !== held_s || c_out !== held_c) stable = 1'b0;
    end
    s  = sum;
    co = c_out;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    step(); step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
    n_checks++; if ({c_out, sum} !== '0) begin n_fail++; $display("FAIL reset_result: got %b_%b expected 0_0000", c_out, sum); end
    start = 1'b1; a = 4'b0101; b = 4'b0011;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_over_start: busy got %b expected 0", busy); end
    rst = 1'b0; start = 1'b0;
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_release: busy got %b expected 0", busy); end
  endtask

  task automatic test_basic();
    logic [W-1:0] s; logic co, ab, st; int lat;
    do_op(4'b0101, 4'b0011, 1'b0, s, co, lat, ab, st);
    n_checks++; if (ab !== 1'b1) begin n_fail++; $display("FAIL basic_busy_rise: got %b expected 1", ab); end
    n_checks++; if (lat != W) begin n_fail++; $display("FAIL basic_latency: got %0d expected %0d", lat, W); end
    n_checks++; if ({co, s} !== 5'b0_1000) begin n_fail++; $display("FAIL basic_result: got %b_%b expected 0_1000", co, s); end
    n_checks++; if (st !== 1'b1) begin n_fail++; $display("FAIL basic_hold: result changed before done"); end
    step();
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL basic_after_done: busy,done got %b%b expected 00", busy, done); end
  endtask

  task automatic test_carry();
    logic [W-1:0] s; logic co, ab, st; int lat;
    do_op(4'b1111, 4'b0001, 1'b0, s, co, lat, ab, st);
    n_checks++; if ({co, s} !== 5'b1_0000) begin n_fail++; $display("FAIL carry_wrap: got %b_%b expected 1_0000", co, s); end
    step();
    do_op(4'b1111, 4'b1111, 1'b1, s, co, lat, ab, st);
    n_checks++; if ({co, s} !== 5'b1_1111) begin n_fail++; $display("FAIL carry_full: got %b_%b expected 1_1111", co, s); end
    n_checks++; if (lat != W) begin n_fail++; $display("FAIL carry_latency: got %0d expected %0d", lat, W); end
    step();
  endtask

  task automatic test_ignored_start();
    int lat;
    a = 4'b0010; b = 4'b0001; c_in = 1'b0; start = 1'b1;
    step();
    start = 1'b0;
    step();
    a = 4'b1111; b = 4'b1111; start = 1'b1;
    step();
    start = 1'b0;
    lat = -1;
    for (int k = 3; k <= W + 4; k++) begin
      step();
      if (done === 1'b1) begin lat = k; break; end
    end
    n_checks++; if (lat != W) begin n_fail++; $display("FAIL ignored_latency: got %0d expected %0d", lat, W); end
    n_checks++; if ({c_out, sum} !== 5'b0_0011) begin n_fail++; $display("FAIL ignored_result: got %b_%b expected 0_0011", c_out, sum); end
    step(); step(); step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL ignored_no_restart: busy got %b expected 0", busy); end

    // start held high through DONE: second acceptance only in the next IDLE cycle
    a = 4'b0011; b = 4'b0100; c_in = 1'b0; start = 1'b1;
    step();
    a = 4'b1001; b = 4'b0110; c_in = 1'b1;
    lat = -1;
    for (int k = 1; k <= W + 4; k++) begin
      step();
      if (done === 1'b1) begin lat = k; break; end
    end
    n_checks++; if ({c_out, sum} !== ref_add(4'b0011, 4'b0100, 1'b0)) begin n_fail++; $display("FAIL held_first: got %b_%b expected 0_0111", c_out, sum); end
    step();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL held_done_ignored: busy got %b expected 0", busy); end
    step();
    start = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL held_idle_accept: busy got %b expected 1", busy); end
    lat = -1;
    for (int k = 1; k <= W + 4; k++) begin
      step();
      if (done === 1'b1) begin lat = k; break; end
    end
    n_checks++; if ({c_out, sum} !== ref_add(4'b1001, 4'b0110, 1'b1)) begin n_fail++; $display("FAIL held_second: got %b_%b expected 1_0000 (lat %0d)", c_out, sum, lat); end
    step();
  endtask

  task automatic test_reset_mid_run();
    logic [W-1:0] s; logic co, ab, st, saw_done; int lat;
    a = 4'b1001; b = 4'b0100; c_in = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_checks++; if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL midrst_state: busy,done got %b%b expected 00", busy, done); end
    n_checks++; if ({c_out, sum} !== '0) begin n_fail++; $display("FAIL midrst_result: got %b_%b expected 0_0000", c_out, sum); end
    saw_done = 1'b0;
    for (int k = 0; k < W + 2; k++) begin
      step();
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
    end
    n_checks++; if (saw_done !== 1'b0) begin n_fail++; $display("FAIL midrst_abort: got activity expected none"); end
    do_op(4'b0110, 4'b0111, 1'b0, s, co, lat, ab, st);
    n_checks++; if ({co, s} !== 5'b0_1101) begin n_fail++; $display("FAIL midrst_fresh: got %b_%b expected 0_1101", co, s); end
    step();
  endtask

  task automatic test_random();
    logic [W-1:0] x, y, s; logic ci, co, ab, st; int lat;
    for (int i = 0; i < 40; i++) begin
      x = W'($urandom); y = W'($urandom); ci = 1'($urandom);
      do_op(x, y, ci, s, co, lat, ab, st);
      n_checks++;
      if ({co, s} !== ref_add(x, y, ci) || lat != W || st !== 1'b1) begin
        n_fail++;
        $display("FAIL random_%0d: %h+%h+%b got %b_%h lat %0d expected %h lat %0d", i, x, y, ci, co, s, lat, ref_add(x, y, ci), W);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] x, y, s; logic ci, co, ab, st; int lat, done_base;
    done_base = n_done;
    for (int i = 0; i < (1 << (2 * W + 1)); i++) begin
      x  = i[W-1:0];
      y  = i[2*W-1:W];
      ci = i[2*W];
      do_op(x, y, ci, s, co, lat, ab, st);
      n_checks++;
      if ({co, s} !== ref_add(x, y, ci) || lat != W) begin
        n_fail++;
        $display("FAIL exhaustive_%0d: %h+%h+%b got %b_%h lat %0d expected %h lat %0d", i, x, y, ci, co, s, lat, ref_add(x, y, ci), W);
      end
      step();
      n_checks++;
      if ({busy, done} !== 2'b00) begin
        n_fail++;
        $display("FAIL exhaustive_pulse_%0d: busy,done got %b%b expected 00", i, busy, done);
      end
    end
    n_checks++;
    if (n_done - done_base != (1 << (2 * W + 1))) begin
      n_fail++;
      $display("FAIL exhaustive_done_count: got %0d expected %0d", n_done - done_base, 1 << (2 * W + 1));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_ignored_start();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
